vector_op_engine: RTL and testbench
===================================

Name: vector_op_engine

Overview:
Parametrised, lane-parallel vector arithmetic engine. It reads two operand vectors A and B from external operand memories and computes either an element-wise vector result (SUM, AVG) or a scalar reduction (MAN, EUC, DOT). It streams results out over a valid/ready interface. It replaces the fixed 8-element single-mode processing core and control pair, adding a lane count, a result buffer, backpressure and error reporting.

Parameters:
NUM_ELEMENTS, 8, elements per vector; must be a multiple of LANES (elaboration error otherwise)
LANES, 4, elements processed per cycle; B = NUM_ELEMENTS/LANES beats per vector
DATA_WIDTH, 10, unsigned operand element width
RESULT_WIDTH, 32, per-lane result width; must be >= 2*DATA_WIDTH+1
ADDR_WIDTH, max(1,$clog2(B)), beat address width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_op  in  3  0=SUM 1=AVG 2=MAN 3=EUC 4=DOT, 5..7 illegal
rd_en  out  1  operand read strobe
rd_addr  out  ADDR_WIDTH  beat address; same address on both memories
rd_data_a  in  LANES*DATA_WIDTH  A beat, lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]; valid 1 cycle after rd_en
rd_data_b  in  LANES*DATA_WIDTH  B beat, same packing and timing
res_valid  out  1  result beat valid
res_ready  in  1  downstream accepts beat
res_data  out  LANES*RESULT_WIDTH  result beat, lane k at [k*RESULT_WIDTH +: RESULT_WIDTH]
res_last  out  1  final beat of the result
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last beat handshake
err  out  1  one-cycle pulse on an illegal op

Behaviour:
- Reset: all outputs 0, except cmd_ready=1 (IDLE). FSM goes to IDLE, accumulator and pipeline valids clear. Reset asserted in any state aborts the operation with no further rd_en, res_valid, done or err.
- FSM states: IDLE, READ, DRAIN, SEND, DONE.
- IDLE:
  - Command is accepted on cmd_valid && cmd_ready (accept cycle T). op is latched and the accumulator is cleared.
  - Legal op -> READ.
  - Illegal op -> err=1 in cycle T+1, no reads, return to IDLE. cmd_ready is 0 in T+1.
- READ: cycles T+1..T+B. rd_en=1; rd_addr counts 0..B-1, one per cycle; no stalls.
- Pipeline:
  - rd_data is registered into stage 1.
  - Stage 2 computes per lane and either writes the vector buffer (beat index = address) or adds the lane sum into the accumulator.
- DRAIN: 2 cycles, waiting for stage 2 to retire. Then -> SEND; first res_valid is in cycle T+B+3.
- Lane arithmetic (unsigned):
  - SUM = a+b, DATA_WIDTH+1 bits, zero-extended.
  - AVG = floor((a+b)/2).
  - MAN = |a-b|.
  - EUC = (a-b)^2; no square root.
  - DOT = a*b.
- Reductions: all lane terms of all beats are summed modulo 2^RESULT_WIDTH, wrapping with no saturation and no flag.
- SEND, vector ops:
  - B beats from the buffer, beat 0 first; res_last on beat B-1.
  - res_data/res_valid/res_last are held stable while res_valid && !res_ready; the beat index advances only on handshake.
- SEND, scalar ops: one beat; lane 0 holds the accumulator, other lanes are 0; res_last=1.
- Last handshake -> DONE: done=1 for one cycle, then IDLE with cmd_ready=1 the next cycle.
- res_ready high while res_valid is low has no effect.
- cmd_valid outside IDLE is ignored; the command is not queued.
- B=1: READ lasts exactly 1 cycle and rd_addr=0.

Test Plan:
1. Defaults, A[i]=i, B[i]=10+i, op SUM, res_ready=1 -> rd_en in T+1..T+2, addr 0,1; res_valid first in T+5. Beat0 lanes 10,12,14,16; beat1 lanes 18,20,22,24 with res_last; done pulse next cycle.
2. Same vectors, AVG -> 5,6,7,8 / 9,10,11,12. MAN -> lane0=80. EUC -> lane0=800. DOT -> lane0=420. Non-zero lanes of scalar beats are 0.
3. SUM with res_ready low for 5 cycles after first res_valid -> beat0 held unchanged for 5 cycles; beats accepted in order; exactly 2 handshakes, one done.
4. cmd_op=7 -> err high in T+1 only; no rd_en, no res_valid, no done; cmd_ready back high in T+2.
5. RESULT_WIDTH=20, all elements 1023, DOT -> lane0 = 8*1023^2 mod 2^20 = 1032200.
6. Reset asserted in the 2nd READ cycle -> next cycle all outputs 0, cmd_ready=1. A following DOT on scenario-1 data returns 420, so no stale accumulator remains.

Source files
------------

// File: rtl/vector_op_engine_if.sv
// Bundle of command, operand-read and result-stream signals for vector_op_engine.
//
// Signals:
//   cmd_valid/cmd_ready/cmd_op    command handshake; op 0=SUM 1=AVG 2=MAN 3=EUC 4=DOT
//   rd_en/rd_addr                 operand read strobe and beat address (shared by both memories)
//   rd_data_a/rd_data_b           operand beats, valid one cycle after rd_en
//   res_valid/res_ready           result beat handshake
//   res_data/res_last             result beat and final-beat marker
//   busy/done/err                 status: not idle, completion pulse, illegal-op pulse
//
// Modports: master = host/memory side, slave = engine side.
interface vector_op_engine_if #(
   parameter int LANES        = 4,
   parameter int DATA_WIDTH   = 10,
   parameter int RESULT_WIDTH = 32,
   parameter int ADDR_WIDTH   = 1
);
   logic                            cmd_valid;
   logic                            cmd_ready;
   logic [2:0]                      cmd_op;
   logic                            rd_en;
   logic [ADDR_WIDTH-1:0]           rd_addr;
   logic [LANES*DATA_WIDTH-1:0]     rd_data_a;
   logic [LANES*DATA_WIDTH-1:0]     rd_data_b;
   logic                            res_valid;
   logic                            res_ready;
   logic [LANES*RESULT_WIDTH-1:0]   res_data;
   logic                            res_last;
   logic                            busy;
   logic                            done;
   logic                            err;

   modport master (
      output cmd_valid, cmd_op, rd_data_a, rd_data_b, res_ready,
      input  cmd_ready, rd_en, rd_addr, res_valid, res_data, res_last, busy, done, err
   );

   modport slave (
      input  cmd_valid, cmd_op, rd_data_a, rd_data_b, res_ready,
      output cmd_ready, rd_en, rd_addr, res_valid, res_data, res_last, busy, done, err
   );
endinterface

// File: rtl/vector_op_engine.sv
// Lane-parallel vector arithmetic engine. Reads operand vectors A and B beat by
// beat, computes an element-wise result (SUM, AVG) into a result buffer or a
// scalar reduction (MAN, EUC, DOT) into an accumulator, then streams the result
// out with valid/ready backpressure.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    vector_op_engine_if.slave: command, operand read, result stream, status
module vector_op_engine #(
   parameter int NUM_ELEMENTS = 8,
   parameter int LANES        = 4,
   parameter int DATA_WIDTH   = 10,
   parameter int RESULT_WIDTH = 32,
   parameter int ADDR_WIDTH   = (NUM_ELEMENTS / LANES > 1) ? $clog2(NUM_ELEMENTS / LANES) : 1
) (
   input logic               clk,
   input logic               reset,
   vector_op_engine_if.slave bus
);
   localparam int BEATS = NUM_ELEMENTS / LANES;
   localparam logic [ADDR_WIDTH-1:0] LAST_BEAT = ADDR_WIDTH'(BEATS - 1);

   localparam logic [2:0] OP_SUM = 3'd0;
   localparam logic [2:0] OP_AVG = 3'd1;
   localparam logic [2:0] OP_MAN = 3'd2;
   localparam logic [2:0] OP_EUC = 3'd3;
   localparam logic [2:0] OP_DOT = 3'd4;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_DRAIN = 3'd2;
   localparam logic [2:0] S_SEND  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   if ((NUM_ELEMENTS % LANES) != 0 || NUM_ELEMENTS < LANES) begin : g_bad_elements
      $error("NUM_ELEMENTS must be a nonzero multiple of LANES");
   end
   if (RESULT_WIDTH < 2 * DATA_WIDTH + 1) begin : g_bad_result_width
      $error("RESULT_WIDTH must be at least 2*DATA_WIDTH+1");
   end

   // Floor halving of the widened sum
   function automatic logic [RESULT_WIDTH-1:0] half_floor(input logic [DATA_WIDTH:0] s);
      return RESULT_WIDTH'(s >> 1);
   endfunction

   function automatic logic [RESULT_WIDTH-1:0] lane_term(input logic [2:0] op,
                                                         input logic [DATA_WIDTH-1:0] a,
                                                         input logic [DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH:0]     sum;
      logic [DATA_WIDTH-1:0]   diff;
      logic [2*DATA_WIDTH-1:0] sq;
      logic [2*DATA_WIDTH-1:0] prod;
      logic [RESULT_WIDTH-1:0] res;
      sum  = {1'b0, a} + {1'b0, b};
      diff = (a >= b) ? (a - b) : (b - a);
      sq   = (2*DATA_WIDTH)'(diff) * (2*DATA_WIDTH)'(diff);
      prod = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
      case (op)
         OP_SUM:  res = RESULT_WIDTH'(sum);
         OP_AVG:  res = half_floor(sum);
         OP_MAN:  res = RESULT_WIDTH'(diff);
         OP_EUC:  res = RESULT_WIDTH'(sq);
         default: res = RESULT_WIDTH'(prod);
      endcase
      return res;
   endfunction

   logic [2:0]                    state;
   logic [2:0]                    op_q;
   logic [ADDR_WIDTH-1:0]         addr_cnt;
   logic [ADDR_WIDTH-1:0]         beat_cnt;
   logic                          drain_cnt;
   logic                          err_q;
   logic                          accept;
   logic                          op_legal;
   logic                          is_scalar;
   logic                          rd_en;
   logic                          res_valid;
   logic                          res_last;
   logic [LANES*RESULT_WIDTH-1:0] res_data;

   logic                          vld_p0;
   logic [ADDR_WIDTH-1:0]         addr_p0;
   logic                          vld_p1;
   logic [ADDR_WIDTH-1:0]         addr_p1;
   logic [LANES*DATA_WIDTH-1:0]   a_p1;
   logic [LANES*DATA_WIDTH-1:0]   b_p1;
   logic [LANES*RESULT_WIDTH-1:0] terms_p2;
   logic [RESULT_WIDTH-1:0]       beat_sum_p2;
   logic [RESULT_WIDTH-1:0]       acc;
   logic [LANES*RESULT_WIDTH-1:0] vec_buf [2**ADDR_WIDTH];

   assign accept    = bus.cmd_valid && bus.cmd_ready;
   assign op_legal  = (bus.cmd_op <= OP_DOT);
   assign is_scalar = (op_q >= OP_MAN);
   assign rd_en     = (state == S_READ);
   assign res_valid = (state == S_SEND);
   assign res_last  = is_scalar || (beat_cnt == LAST_BEAT);

   // Control FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         op_q      <= OP_SUM;
         addr_cnt  <= '0;
         beat_cnt  <= '0;
         drain_cnt <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (op_legal) begin
                     op_q  <= bus.cmd_op;
                     state <= S_READ;
                  end else begin
                     // Illegal op: flag it and stay idle; cmd_ready drops for the flag cycle
                     err_q <= 1'b1;
                  end
               end
            end
            S_READ: begin
               if (addr_cnt == LAST_BEAT) begin
                  addr_cnt <= '0;
                  state    <= S_DRAIN;
               end else begin
                  addr_cnt <= addr_cnt + 1'b1;
               end
            end
            S_DRAIN: begin
               // Two cycles: one for the memory read latency, one for stage 1
               drain_cnt <= ~drain_cnt;
               if (drain_cnt) state <= S_SEND;
            end
            S_SEND: begin
               if (bus.res_ready) begin
                  if (res_last) begin
                     beat_cnt <= '0;
                     state    <= S_DONE;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Pipeline valids and accumulator (cleared by reset so an abort leaves nothing behind)
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         acc    <= '0;
      end else begin
         vld_p0 <= rd_en;
         vld_p1 <= vld_p0;
         if (state == S_IDLE && accept) begin
            acc <= '0;
         end else if (vld_p1 && is_scalar) begin
            acc <= acc + beat_sum_p2;
         end
      end
   end

   // Stage 0 -> 1: operand beat arrives one cycle after rd_en and is registered
   always_ff @(posedge clk) begin
      addr_p0 <= addr_cnt;
      if (vld_p0) begin
         a_p1    <= bus.rd_data_a;
         b_p1    <= bus.rd_data_b;
         addr_p1 <= addr_p0;
      end
      if (vld_p1 && !is_scalar) begin
         vec_buf[addr_p1] <= terms_p2;
      end
   end

   // Stage 2: per-lane terms and their beat sum
   always_comb begin
      terms_p2    = '0;
      beat_sum_p2 = '0;
      for (int k = 0; k < LANES; k++) begin
         terms_p2[k*RESULT_WIDTH +: RESULT_WIDTH] =
            lane_term(op_q, a_p1[k*DATA_WIDTH +: DATA_WIDTH], b_p1[k*DATA_WIDTH +: DATA_WIDTH]);
         beat_sum_p2 = beat_sum_p2 + terms_p2[k*RESULT_WIDTH +: RESULT_WIDTH];
      end
   end

   always_comb begin
      res_data = '0;
      if (res_valid) begin
         res_data = is_scalar ? (LANES*RESULT_WIDTH)'(acc) : vec_buf[beat_cnt];
      end
   end

   assign bus.cmd_ready = (state == S_IDLE) && !err_q;
   assign bus.rd_en     = rd_en;
   assign bus.rd_addr   = addr_cnt;
   assign bus.res_valid = res_valid;
   assign bus.res_data  = res_data;
   assign bus.res_last  = res_valid && res_last;
   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = (state == S_DONE);
   assign bus.err       = err_q;
endmodule

// File: tb/tb_vector_op_engine.sv
// Self-checking bench for vector_op_engine: directed test-plan steps followed by
// randomized operations, checked against an element-level reference model.
`timescale 1ns/1ps
module tb_vector_op_engine;
   localparam int NE = 8;
   localparam int DW = 10;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vector_op_engine_if #(.LANES(4), .DATA_WIDTH(DW), .RESULT_WIDTH(32), .ADDR_WIDTH(1)) bus0 ();
   vector_op_engine_if #(.LANES(8), .DATA_WIDTH(DW), .RESULT_WIDTH(20), .ADDR_WIDTH(1)) bus1 ();

   vector_op_engine #(.NUM_ELEMENTS(NE), .LANES(4), .DATA_WIDTH(DW), .RESULT_WIDTH(32)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0));
   vector_op_engine #(.NUM_ELEMENTS(NE), .LANES(8), .DATA_WIDTH(DW), .RESULT_WIDTH(20)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1));

   int unsigned mem_a [NE];
   int unsigned mem_b [NE];

   function automatic logic [8*DW-1:0] pack(input int lanes, input int beat, input bit use_b);
      logic [8*DW-1:0] v;
      v = '0;
      for (int k = 0; k < lanes; k++)
         v[k*DW +: DW] = DW'(use_b ? mem_b[beat*lanes+k] : mem_a[beat*lanes+k]);
      return v;
   endfunction

   // Operand memories: registered read, data one cycle after rd_en
   always @(posedge clk) begin
      if (bus0.rd_en) begin
         bus0.rd_data_a <= (4*DW)'(pack(4, int'(bus0.rd_addr), 1'b0));
         bus0.rd_data_b <= (4*DW)'(pack(4, int'(bus0.rd_addr), 1'b1));
      end
      if (bus1.rd_en) begin
         bus1.rd_data_a <= pack(8, int'(bus1.rd_addr), 1'b0);
         bus1.rd_data_b <= pack(8, int'(bus1.rd_addr), 1'b1);
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check_bit(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
      end
   endtask

   task automatic check_vec(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic s_cmd_ready, s_rd_en, s_res_valid, s_res_last, s_busy, s_done, s_err;
   logic [0:0]   s_rd_addr;
   logic [255:0] s_res_data;

   task automatic sample(input int sel);
      if (sel == 0) begin
         s_cmd_ready = bus0.cmd_ready; s_rd_en = bus0.rd_en; s_rd_addr = bus0.rd_addr;
         s_res_valid = bus0.res_valid; s_res_last = bus0.res_last; s_res_data = 256'(bus0.res_data);
         s_busy = bus0.busy; s_done = bus0.done; s_err = bus0.err;
      end else begin
         s_cmd_ready = bus1.cmd_ready; s_rd_en = bus1.rd_en; s_rd_addr = bus1.rd_addr;
         s_res_valid = bus1.res_valid; s_res_last = bus1.res_last; s_res_data = 256'(bus1.res_data);
         s_busy = bus1.busy; s_done = bus1.done; s_err = bus1.err;
      end
   endtask

   task automatic drive(input int sel, input logic cv, input logic [2:0] op, input logic rr);
      if (sel == 0) begin
         bus0.cmd_valid = cv; bus0.cmd_op = op; bus0.res_ready = rr;
      end else begin
         bus1.cmd_valid = cv; bus1.cmd_op = op; bus1.res_ready = rr;
      end
   endtask

   task automatic check_quiet(input int sel, input string tag);
      sample(sel);
      check_bit({tag, "_cmd_ready"}, s_cmd_ready, 1'b1);
      check_bit({tag, "_rd_en"}, s_rd_en, 1'b0);
      check_vec({tag, "_rd_addr"}, 256'(s_rd_addr), '0);
      check_bit({tag, "_res_valid"}, s_res_valid, 1'b0);
      check_vec({tag, "_res_data"}, s_res_data, '0);
      check_bit({tag, "_res_last"}, s_res_last, 1'b0);
      check_bit({tag, "_busy"}, s_busy, 1'b0);
      check_bit({tag, "_done"}, s_done, 1'b0);
      check_bit({tag, "_err"}, s_err, 1'b0);
   endtask

   // Reference model: element-level arithmetic, independent of lanes and beats
   function automatic longint unsigned elem(input int op, input longint unsigned a,
                                            input longint unsigned b);
      longint unsigned d;
      d = (a > b) ? a - b : b - a;
      case (op)
         0:       return a + b;
         1:       return (a + b) / 2;
         2:       return d;
         3:       return d * d;
         default: return a * b;
      endcase
   endfunction

   logic [255:0] exp_beats [$];

   task automatic build_expected(input int sel, input int op);
      int lanes;
      int rw;
      longint unsigned s;
      logic [255:0] v;
      lanes = (sel == 0) ? 4 : 8;
      rw    = (sel == 0) ? 32 : 20;
      exp_beats.delete();
      if (op >= 2) begin
         s = 0;
         for (int i = 0; i < NE; i++) s += elem(op, mem_a[i], mem_b[i]);
         s = s & ((64'd1 << rw) - 1);
         exp_beats.push_back(256'(s));
      end else begin
         for (int bt = 0; bt < NE / lanes; bt++) begin
            v = '0;
            for (int k = 0; k < lanes; k++)
               v = v | (256'(elem(op, mem_a[bt*lanes+k], mem_b[bt*lanes+k])) << (k*rw));
            exp_beats.push_back(v);
         end
      end
   endtask

   logic [255:0] first_beat;
   logic [255:0] last_beat;

   // One complete operation; starts and ends at a falling edge with the DUT idle.
   // Cycle c counts from the accept edge T (c=1 is T+1).
   task automatic run_op(input int sel, input int op, input int stall);
      int beats, nb, v_cyc, last_hs, idx;
      logic exp_valid, rr;
      beats = (sel == 0) ? 2 : 1;
      build_expected(sel, op);
      nb      = exp_beats.size();
      v_cyc   = beats + 3;
      last_hs = v_cyc + stall + nb - 1;
      sample(sel);
      check_bit("cmd_ready_idle", s_cmd_ready, 1'b1);
      drive(sel, 1'b1, 3'(op), 1'($urandom_range(0, 1)));
      @(negedge clk);
      for (int c = 1; c <= last_hs + 2; c++) begin
         sample(sel);
         check_bit($sformatf("rd_en@%0d", c), s_rd_en, c <= beats);
         if (c <= beats) check_vec($sformatf("rd_addr@%0d", c), 256'(s_rd_addr), 256'(c - 1));
         exp_valid = (c >= v_cyc) && (c <= last_hs);
         check_bit($sformatf("res_valid@%0d", c), s_res_valid, exp_valid);
         if (exp_valid) begin
            idx = (c < v_cyc + stall) ? 0 : c - v_cyc - stall;
            check_vec($sformatf("res_data_beat%0d@%0d", idx, c), s_res_data, exp_beats[idx]);
            check_bit($sformatf("res_last@%0d", c), s_res_last, idx == nb - 1);
            if (idx == 0) first_beat = s_res_data;
            last_beat = s_res_data;
         end
         check_bit($sformatf("done@%0d", c), s_done, c == last_hs + 1);
         check_bit($sformatf("busy@%0d", c), s_busy, c <= last_hs + 1);
         check_bit($sformatf("err@%0d", c), s_err, 1'b0);
         if (c == 1 || c == last_hs + 2)
            check_bit($sformatf("cmd_ready@%0d", c), s_cmd_ready, c == last_hs + 2);
         // res_ready is random while no beat is offered, low during the stall window
         if (c < v_cyc) rr = 1'($urandom_range(0, 1));
         else if (c < v_cyc + stall) rr = 1'b0;
         else if (c <= last_hs) rr = 1'b1;
         else rr = 1'($urandom_range(0, 1));
         // Junk commands while busy must be ignored
         drive(sel, c <= last_hs, 3'($urandom_range(0, 7)), rr);
         @(negedge clk);
      end
      drive(sel, 1'b0, 3'd0, 1'b0);
   endtask

   task automatic run_illegal(input int op);
      drive(0, 1'b1, 3'(op), 1'b0);
      @(negedge clk);
      drive(0, 1'b0, 3'd0, 1'b1);
      for (int c = 1; c <= 6; c++) begin
         sample(0);
         check_bit($sformatf("ill%0d_err@%0d", op, c), s_err, c == 1);
         check_bit($sformatf("ill%0d_cmd_ready@%0d", op, c), s_cmd_ready, c != 1);
         check_bit($sformatf("ill%0d_rd_en@%0d", op, c), s_rd_en, 1'b0);
         check_bit($sformatf("ill%0d_res_valid@%0d", op, c), s_res_valid, 1'b0);
         check_bit($sformatf("ill%0d_done@%0d", op, c), s_done, 1'b0);
         check_bit($sformatf("ill%0d_busy@%0d", op, c), s_busy, 1'b0);
         @(negedge clk);
      end
      drive(0, 1'b0, 3'd0, 1'b0);
   endtask

   task automatic load_ramp();
      for (int i = 0; i < NE; i++) begin
         mem_a[i] = i;
         mem_b[i] = 10 + i;
      end
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 1'b0, 3'd0, 1'b0);
      drive(1, 1'b0, 3'd0, 1'b0);
      load_ramp();
      repeat (3) @(negedge clk);
      check_quiet(0, "rst0");
      check_quiet(1, "rst1");
      reset = 1'b0;
      @(negedge clk);

      // Ramp data, every legal op, no backpressure
      run_op(0, 0, 0);
      check_vec("sum_beat0", first_beat, {160'd0, 32'd16, 32'd14, 32'd12, 32'd10});
      check_vec("sum_beat1", last_beat, {160'd0, 32'd24, 32'd22, 32'd20, 32'd18});
      run_op(0, 1, 0);
      check_vec("avg_beat0", first_beat, {160'd0, 32'd8, 32'd7, 32'd6, 32'd5});
      run_op(0, 2, 0);
      check_vec("man_scalar", last_beat, 256'd80);
      run_op(0, 3, 0);
      check_vec("euc_scalar", last_beat, 256'd800);
      run_op(0, 4, 0);
      check_vec("dot_scalar", last_beat, 256'd420);

      // Backpressure: first beat held for 5 cycles
      run_op(0, 0, 5);

      // Illegal ops
      run_illegal(7);
      run_illegal(5);

      // Reset during the second READ cycle
      drive(0, 1'b1, 3'd0, 1'b1);
      @(negedge clk);
      drive(0, 1'b0, 3'd0, 1'b1);
      sample(0);
      check_bit("abort_rd_en1", s_rd_en, 1'b1);
      @(negedge clk);
      sample(0);
      check_bit("abort_rd_en2", s_rd_en, 1'b1);
      check_vec("abort_rd_addr2", 256'(s_rd_addr), 256'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_quiet(0, "abort");
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check_quiet(0, $sformatf("post_abort%0d", c));
      end
      run_op(0, 4, 0);
      check_vec("dot_after_abort", last_beat, 256'd420);

      // Narrow result with wrap, single-beat configuration
      for (int i = 0; i < NE; i++) begin
         mem_a[i] = 1023;
         mem_b[i] = 1023;
      end
      run_op(1, 4, 0);
      check_vec("dot_wrap", last_beat, 256'd1032200);
      load_ramp();
      run_op(1, 0, 2);
      run_op(1, 3, 1);

      // Randomized operations on both configurations
      for (int n = 0; n < 24; n++) begin
         for (int i = 0; i < NE; i++) begin
            mem_a[i] = $urandom_range(0, 1023);
            mem_b[i] = $urandom_range(0, 1023);
         end
         run_op(n % 2, $urandom_range(0, 4), $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
